// File: rtl/carpici_ardisik.sv
// carpici_ardisik -- multi-cycle W x W multiplier with RISC-V style result selection.
//
// Operands are converted to magnitudes at the accepting edge. The magnitudes are
// multiplied ADIM_BIT multiplier bits per cycle, and the 2W-bit product is negated
// in a final correction cycle when exactly one effective operand is negative.
//
// Ports:
//   clk_i            rising-edge clock
//   rstn_i           asynchronous active-low reset
//   temizle_i        synchronous flush, aborts any operation, highest priority
//   istek_gecerli_i  request valid
//   istek_hazir_o    ready to accept a request (high only when idle)
//   islec0_i         multiplicand (W bits)
//   islec1_i         multiplier (W bits)
//   islem_i          00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   sonuc_gecerli_o  result valid
//   sonuc_hazir_i    consumer ready
//   carpim_o         full 2W-bit product
//   sonuc_o          low half for MUL, high half otherwise
//   durum_o          current FSM state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once valid is raised it stays high, with stable data, until that edge.
module carpici_ardisik #(
    parameter int VERI_GENISLIK = 32,
    parameter int ADIM_BIT      = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         temizle_i,
    input  logic                         istek_gecerli_i,
    output logic                         istek_hazir_o,
    input  logic [VERI_GENISLIK-1:0]     islec0_i,
    input  logic [VERI_GENISLIK-1:0]     islec1_i,
    input  logic [1:0]                   islem_i,
    output logic                         sonuc_gecerli_o,
    input  logic                         sonuc_hazir_i,
    output logic [2*VERI_GENISLIK-1:0]   carpim_o,
    output logic [VERI_GENISLIK-1:0]     sonuc_o,
    output logic [1:0]                   durum_o
);
    localparam int W  = VERI_GENISLIK;
    localparam int K  = ADIM_BIT;
    localparam int N  = W / K;
    localparam int SW = $clog2(N + 1);

    generate
        if (!((K == 1) || (K == 2) || (K == 4) || (K == 8)) || ((W % K) != 0)) begin : g_param_hata
            $error("carpici_ardisik: ADIM_BIT must be 1, 2, 4 or 8 and divide VERI_GENISLIK");
        end
    endgenerate

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        DUZELT  = 2'd2,
        SONUC   = 2'd3
    } durum_t;

    durum_t r_durum;
    durum_t w_sonraki;

    logic [W-1:0]   r_mag0;
    logic [W-1:0]   r_mag1;
    logic           r_negate;
    logic [1:0]     r_islem;
    logic [2*W-1:0] r_acc;
    logic [SW-1:0]  r_sayac;
    logic           r_gecerli;
    logic [2*W-1:0] r_carpim;
    logic [W-1:0]   r_sonuc;

    logic           w_isaret0;
    logic           w_isaret1;
    logic [W-1:0]   w_mag0;
    logic [W-1:0]   w_mag1;
    logic [2*W-1:0] w_kismi;
    logic [2*W-1:0] w_carpim;
    logic           w_son_adim;

    // MUL is treated as unsigned: its low half does not depend on signedness.
    assign w_isaret0 = islec0_i[W-1] & ((islem_i == 2'b01) || (islem_i == 2'b10));
    assign w_isaret1 = islec1_i[W-1] & (islem_i == 2'b01);
    // -(2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign w_mag0    = w_isaret0 ? -islec0_i : islec0_i;
    assign w_mag1    = w_isaret1 ? -islec1_i : islec1_i;

    // Partial product of the whole multiplicand with the next K multiplier bits,
    // aligned to the bit position those K bits had in the original multiplier.
    assign w_kismi    = ({{W{1'b0}}, r_mag0} * {{(2*W-K){1'b0}}, r_mag1[K-1:0]})
                        << (32'(r_sayac) * K);
    assign w_carpim   = r_negate ? -r_acc : r_acc;
    assign w_son_adim = (r_sayac == SW'(N - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    always_comb begin
        w_sonraki = r_durum;
        if (temizle_i) begin
            w_sonraki = BOSTA;
        end else begin
            case (r_durum)
                BOSTA:   if (istek_gecerli_i) w_sonraki = HESAPLA;
                HESAPLA: if (w_son_adim)      w_sonraki = DUZELT;
                DUZELT:                       w_sonraki = SONUC;
                SONUC:   if (sonuc_hazir_i)   w_sonraki = BOSTA;
                default:                      w_sonraki = BOSTA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mag0    <= '0;
            r_mag1    <= '0;
            r_negate  <= 1'b0;
            r_islem   <= 2'b00;
            r_acc     <= '0;
            r_sayac   <= '0;
            r_gecerli <= 1'b0;
            r_carpim  <= '0;
            r_sonuc   <= '0;
        end else if (temizle_i) begin
            // Result registers keep their last value; only the valid flag drops.
            r_gecerli <= 1'b0;
        end else begin
            case (r_durum)
                BOSTA: begin
                    if (istek_gecerli_i) begin
                        r_mag0   <= w_mag0;
                        r_mag1   <= w_mag1;
                        r_negate <= w_isaret0 ^ w_isaret1;
                        r_islem  <= islem_i;
                        r_acc    <= '0;
                        r_sayac  <= '0;
                    end
                end
                HESAPLA: begin
                    r_acc   <= r_acc + w_kismi;
                    r_mag1  <= r_mag1 >> K;
                    r_sayac <= r_sayac + SW'(1);
                end
                DUZELT: begin
                    r_carpim  <= w_carpim;
                    r_sonuc   <= (r_islem == 2'b00) ? w_carpim[W-1:0] : w_carpim[2*W-1:W];
                    r_gecerli <= 1'b1;
                end
                SONUC: begin
                    if (sonuc_hazir_i) r_gecerli <= 1'b0;
                end
                default: begin
                    r_gecerli <= 1'b0;
                end
            endcase
        end
    end

    assign istek_hazir_o   = (r_durum == BOSTA);
    assign sonuc_gecerli_o = r_gecerli;
    assign carpim_o        = r_carpim;
    assign sonuc_o         = r_sonuc;
    assign durum_o         = r_durum;

endmodule

// File: tb/tb_carpici_ardisik.sv
module tb_carpici_ardisik;
    logic        clk;
    logic        rstn;
    logic        temizle;
    logic        istek_gecerli;
    logic        istek_hazir;
    logic [31:0] islec0;
    logic [31:0] islec1;
    logic [1:0]  islem;
    logic        sonuc_gecerli;
    logic        sonuc_hazir;
    logic [63:0] carpim;
    logic [31:0] sonuc;
    logic [1:0]  durum;

    int n_test = 0;
    int n_fail = 0;

    carpici_ardisik #(.VERI_GENISLIK(32), .ADIM_BIT(4)) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .temizle_i       (temizle),
        .istek_gecerli_i (istek_gecerli),
        .istek_hazir_o   (istek_hazir),
        .islec0_i        (islec0),
        .islec1_i        (islec1),
        .islem_i         (islem),
        .sonuc_gecerli_o (sonuc_gecerli),
        .sonuc_hazir_i   (sonuc_hazir),
        .carpim_o        (carpim),
        .sonuc_o         (sonuc),
        .durum_o         (durum)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_test++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic send(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        @(negedge clk);
        check({tag, "_ready"}, istek_hazir, 1);
        istek_gecerli = 1'b1;
        islec0        = a;
        islec1        = b;
        islem         = op;
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; the result must not depend on them.
        istek_gecerli = 1'b0;
        islec0        = $urandom;
        islec1        = $urandom;
        islem         = 2'($urandom_range(0, 3));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_c,
                          input logic [31:0] exp_s);
        int edges;
        send(tag, op, a, b);
        edges = 0;
        while (sonuc_gecerli !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, 9);
        check({tag, "_carpim"}, carpim, exp_c);
        check({tag, "_sonuc"}, sonuc, exp_s);
        if (sonuc_hazir) begin
            @(posedge clk);
            #1;
            check({tag, "_valid_drop"}, sonuc_gecerli, 0);
            check({tag, "_ready_back"}, istek_hazir, 1);
        end
    endtask

    initial begin
        int bad;
        logic [63:0] saved_c;
        logic [31:0] saved_s;

        rstn          = 1'b0;
        temizle       = 1'b0;
        istek_gecerli = 1'b0;
        islec0        = '0;
        islec1        = '0;
        islem         = 2'b00;
        sonuc_hazir   = 1'b1;

        #2;
        check("rst_valid", sonuc_gecerli, 0);
        check("rst_ready", istek_hazir, 1);
        check("rst_carpim", carpim, 0);
        check("rst_sonuc", sonuc, 0);
        check("rst_durum", durum, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Basic MUL, latency and one-cycle valid
        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 64'h2A, 32'h2A);

        // Signed variants on all-ones operands
        run_op("mul_ff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'h00000001);
        run_op("mulh_ff",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 32'h00000000);
        run_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000001, 32'hFFFFFFFF);
        run_op("mulhu_ff",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE);

        // Most-negative operand boundaries
        run_op("mulh_min_min", 2'b01, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32'h40000000);
        run_op("mulh_min_1",   2'b01, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 32'hFFFFFFFF);
        run_op("mulhsu_min_ff", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h8000000080000000, 32'h80000000);

        // Mixed patterns
        run_op("mulh_3_m5",  2'b01, 32'd3, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1, 32'hFFFFFFFF);
        run_op("mul_carry",  2'b00, 32'h00010000, 32'h00010000, 64'h0000000100000000, 32'h00000000);
        run_op("mulhu_ffx2", 2'b11, 32'hFFFFFFFF, 32'd2, 64'h00000001FFFFFFFE, 32'h00000001);

        // Backpressure: hold the result for 20 cycles
        @(negedge clk);
        sonuc_hazir = 1'b0;
        run_op("bp", 2'b00, 32'd1000, 32'd1000, 64'd1000000, 32'd1000000);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (sonuc_gecerli !== 1'b1 || istek_hazir !== 1'b0 ||
                carpim !== 64'd1000000 || sonuc !== 32'd1000000) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        @(negedge clk);
        sonuc_hazir = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", sonuc_gecerli, 0);
        check("bp_release_ready", istek_hazir, 1);

        // Flush three cycles after accept
        saved_c = carpim;
        saved_s = sonuc;
        send("fl", 2'b00, 32'd7, 32'd6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        temizle = 1'b1;
        @(posedge clk);
        #1;
        temizle = 1'b0;
        check("fl_ready", istek_hazir, 1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (sonuc_gecerli !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check("fl_no_valid_bad", bad, 0);
        check("fl_carpim_kept", carpim, saved_c);
        check("fl_sonuc_kept", sonuc, saved_s);
        run_op("after_fl_3x5", 2'b00, 32'd3, 32'd5, 64'd15, 32'd15);

        // Flush while a result is held, coinciding with consume
        @(negedge clk);
        sonuc_hazir = 1'b0;
        run_op("fl_sonuc", 2'b11, 32'h00000010, 32'h20000000, 64'h0000000200000000, 32'h00000002);
        @(negedge clk);
        temizle     = 1'b1;
        sonuc_hazir = 1'b1;
        @(posedge clk);
        #1;
        temizle = 1'b0;
        check("fl_sonuc_valid", sonuc_gecerli, 0);
        check("fl_sonuc_ready", istek_hazir, 1);
        check("fl_sonuc_carpim_kept", carpim, 64'h0000000200000000);

        // Asynchronous reset in the middle of a computation
        send("rst_mid", 2'b01, 32'hFFFFFFFF, 32'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_valid", sonuc_gecerli, 0);
        check("rst_mid_ready", istek_hazir, 1);
        check("rst_mid_carpim", carpim, 0);
        check("rst_mid_sonuc", sonuc, 0);
        check("rst_mid_durum", durum, 0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (sonuc_gecerli !== 1'b0) bad++;
        end
        check("rst_mid_no_valid_bad", bad, 0);
        run_op("after_rst", 2'b01, 32'hFFFFFFFE, 32'd4, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFFF);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

// File: doc/carpici_ardisik.md
Name: carpici_ardisik

Overview:
- Parametrised, multi-cycle successor to the combinational 32x32 multiplier core.
- Computes the full 2W-bit product of two W-bit operands, plus the W-bit result selected by a RISC-V style operation code (MUL/MULH/MULHSU/MULHU).
- Retires ADIM_BIT multiplier bits per cycle. A valid/ready handshake sits on each side, so it drops into the execute stage as a stallable functional unit.
- Sign handling is magnitude-based: multiply operand magnitudes, then conditionally negate the product.

Parameters:
- VERI_GENISLIK, 32, operand width W.
- ADIM_BIT, 4, multiplier bits consumed per compute cycle K.
  - Legal values: 1, 2, 4, 8.
  - W mod K must be 0; otherwise elaboration fails with $error.

Ports:
- clk_i  input  1  clock, rising edge
- rstn_i  input  1  asynchronous active-low reset
- temizle_i  input  1  synchronous flush; aborts any operation
- istek_gecerli_i  input  1  request valid
- istek_hazir_o  output  1  ready to accept request
- islec0_i  input  W  multiplicand
- islec1_i  input  W  multiplier
- islem_i  input  2  op code
  - 00 MUL (low half)
  - 01 MULH (signed x signed, high half)
  - 10 MULHSU (signed x unsigned, high half)
  - 11 MULHU (unsigned x unsigned, high half)
- sonuc_gecerli_o  output  1  result valid
- sonuc_hazir_i  input  1  consumer ready
- carpim_o  output  2W  full product, interpreted per islem
- sonuc_o  output  W  selected half: low for MUL, high otherwise

Behaviour:
- Reset (rstn_i low, asynchronous):
  - State BOSTA; istek_hazir_o=1.
  - sonuc_gecerli_o=0, carpim_o=0, sonuc_o=0.
  - Internal accumulator, counter and sign flag cleared.
- Signedness:
  - islec0 is signed for op 01 and op 10.
  - islec1 is signed for op 01 only.
  - MUL is treated as unsigned; the low half is identical either way.
  - Negative signed operands are replaced by their two's-complement magnitude. The magnitude of 2^(W-1) is representable in W unsigned bits.
  - Negate flag = XOR of the two effective operand signs.
- State BOSTA:
  - istek_hazir_o=1.
  - On an edge with istek_gecerli_i=1, latch:
    - magnitudes;
    - negate flag;
    - op code;
    - accumulator = 0;
    - counter = 0.
  - Go to HESAPLA.
- State HESAPLA:
  - istek_hazir_o=0.
  - Each cycle: accumulator += (magnitude0 x low K bits of multiplier magnitude) << (counter*K). Multiplier shifts right by K; counter increments.
  - After N=W/K steps, go to DUZELT.
- State DUZELT:
  - One cycle.
  - Product = negate ? two's complement of accumulator (2W bits) : accumulator.
  - Register carpim_o and sonuc_o; set sonuc_gecerli_o=1; go to SONUC.
- Latency:
  - sonuc_gecerli_o is first high after edge T+N+1, where T is the accepting edge.
  - Default parameters: N=8, so valid after 9 edges.
- State SONUC:
  - Outputs held stable while sonuc_hazir_i=0 (backpressure, indefinite).
  - On an edge with sonuc_hazir_i=1: sonuc_gecerli_o=0, return to BOSTA.
  - No new request is accepted in that same edge. Issue rate is one per N+3 cycles minimum.
- Flush (temizle_i=1 on an edge):
  - Takes priority over every other event, including a simultaneous accept or consume.
  - Go to BOSTA; sonuc_gecerli_o=0.
  - carpim_o and sonuc_o retain their last value.
  - No result is ever produced for the aborted request.
- Reset mid-operation: identical to the power-on reset values. The in-flight request is lost.
- Inputs islec0_i, islec1_i and islem_i are sampled only at the accepting edge. Later changes have no effect.
- Output widths: carpim_o is always exact modulo 2^(2W); no overflow is signalled.

Test Plan:
1. MUL, W=32, K=4: islec0=7, islec1=6, sonuc_hazir_i=1 → sonuc_o=0x0000002A, carpim_o=0x2A, valid exactly 9 edges after accept, one cycle wide.
2. Signed ops on 0xFFFFFFFF x 0xFFFFFFFF:
   - MULH → carpim_o=0x0000000000000001, sonuc_o=0x00000000.
   - MULHSU → carpim_o=0xFFFFFFFF00000001, sonuc_o=0xFFFFFFFF.
   - MULHU → carpim_o=0xFFFFFFFE00000001, sonuc_o=0xFFFFFFFE.
3. MULH 0x80000000 x 0x80000000 → carpim_o=0x4000000000000000, sonuc_o=0x40000000.
   - MULH 0x80000000 x 0x00000001 → sonuc_o=0xFFFFFFFF.
4. Backpressure: hold sonuc_hazir_i=0 for 20 cycles after valid → outputs stable and istek_hazir_o=0 throughout. Raise sonuc_hazir_i → valid drops next edge and istek_hazir_o=1.
5. Flush and reset:
   - temizle_i pulsed 3 cycles after accept → no sonuc_gecerli_o pulse, istek_hazir_o=1 next cycle. A following 3x5 request yields 15.
   - rstn_i pulsed low mid-HESAPLA → all outputs read reset values immediately.
6. Parameter sweep W=16 with K in {1,2,8}: 500 random operand/op pairs vs. behavioural reference → exact match, valid after W/K+1 edges. Also confirm W=32, K=3 fails elaboration.
